// File: rtl/branch_resolve.sv
// branch_resolve: carries prediction metadata IF->ID->EX, resolves branches, drives predictor update and redirect
module branch_resolve #(
  parameter int ENTRYNUM = 8,
  localparam int HW = $clog2(ENTRYNUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_pc_pre,
  input  logic          if_hit,
  input  logic [HW-1:0] if_hitpos,
  input  logic          ex_branch,
  input  logic          ex_taken,
  input  logic [31:0]   ex_target,
  output logic [31:0]   pc_ex,
  output logic [31:0]   pc_npc,
  output logic [HW-1:0] hitpos_ex,
  output logic          hit_ex,
  output logic          preright_ex,
  output logic          branch_ex,
  output logic          redirect,
  output logic [31:0]   redirect_pc,
  output logic          ex_valid,
  output logic [31:0]   cnt_branch,
  output logic [31:0]   cnt_mispred
);
  logic          id_valid, id_hit, ex_hit, mis, q;
  logic [31:0]   id_pc, id_pc_pre, ex_pc_pre;
  logic [HW-1:0] id_hitpos;
  always_comb begin
    pc_npc      = (ex_branch & ex_taken) ? ex_target : pc_ex + 32'd1;
    mis         = ex_valid & (pc_npc != ex_pc_pre);
    q           = ex_valid & ~stall;
    branch_ex   = q & ex_branch;
    hit_ex      = q & ex_hit;
    preright_ex = ~mis;
    redirect    = q & mis;
    redirect_pc = pc_npc;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_pc_pre   <= '0;
      id_hit      <= 1'b0;
      id_hitpos   <= '0;
      ex_valid    <= 1'b0;
      pc_ex       <= '0;
      ex_pc_pre   <= '0;
      ex_hit      <= 1'b0;
      hitpos_ex   <= '0;
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else if (!stall) begin
      id_valid    <= if_valid & ~redirect;
      id_pc       <= if_pc;
      id_pc_pre   <= if_pc_pre;
      id_hit      <= if_hit;
      id_hitpos   <= if_hitpos;
      ex_valid    <= id_valid & ~redirect;
      pc_ex       <= id_pc;
      ex_pc_pre   <= id_pc_pre;
      ex_hit      <= id_hit;
      hitpos_ex   <= id_hitpos;
      cnt_branch  <= cnt_branch + {31'd0, branch_ex};
      cnt_mispred <= cnt_mispred + {31'd0, redirect};
    end
  end
endmodule
